// File: rtl/issue_queue_sched.sv
// Reservation-station issue queue: lowest-free-slot allocation, oldest-ready
// selection with age counters, and a SEL/HOLD lock that keeps the offered entry stable.
module issue_queue_sched #(
    parameter int unsigned N       = 8,
    parameter int unsigned AGE_LEN = 4,
    parameter int unsigned TAG_W   = 6,
    localparam int unsigned IW     = $clog2(N),
    localparam int unsigned CW     = $clog2(N + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             ins_valid_i,
    output logic             ins_ready_o,
    input  logic [TAG_W-1:0] ins_tag_i,
    input  logic             ins_rdy_i,
    output logic [IW-1:0]    ins_idx_o,
    input  logic [N-1:0]     wake_i,
    output logic             iss_valid_o,
    input  logic             iss_ready_i,
    output logic [IW-1:0]    iss_idx_o,
    output logic [TAG_W-1:0] iss_tag_o,
    output logic [CW-1:0]    count_o
);

    typedef enum logic {SEL, HOLD} state_t;

    state_t             state_q;
    logic [N-1:0]       valid_q;
    logic [N-1:0]       rdy_q;
    logic [AGE_LEN-1:0] age_q [N];
    logic [TAG_W-1:0]   tag_q [N];
    logic [IW-1:0]      lock_q;

    logic               free_found;
    logic [N-1:0]       cand;
    logic               sel_found;
    logic [IW-1:0]      sel_idx;
    logic [AGE_LEN-1:0] best_age;
    logic               ins_fire;
    logic               iss_fire;

    always_comb begin
        ins_idx_o  = '0;
        free_found = 1'b0;
        count_o    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!valid_q[i] && !free_found) begin
                ins_idx_o  = IW'(i);
                free_found = 1'b1;
            end
            count_o = count_o + CW'(valid_q[i]);
        end
    end

    assign ins_ready_o = ~&valid_q;

    // Ascending scan with >= lets a later equal-age entry win the tie.
    always_comb begin
        cand      = valid_q & rdy_q;
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cand[i] && (!sel_found || age_q[i] >= best_age)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
                best_age  = age_q[i];
            end
        end
    end

    always_comb begin
        if (state_q == HOLD) begin
            iss_valid_o = 1'b1;
            iss_idx_o   = lock_q;
        end else begin
            iss_valid_o = sel_found;
            iss_idx_o   = sel_idx;
        end
        iss_tag_o = iss_valid_o ? tag_q[iss_idx_o] : '0;
    end

    assign ins_fire = ins_valid_i && ins_ready_o;
    assign iss_fire = iss_valid_o && iss_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= SEL;
            valid_q <= '0;
            rdy_q   <= '0;
            lock_q  <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                age_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
            state_q <= SEL;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (valid_q[i] && wake_i[i])
                    rdy_q[i] <= 1'b1;
                if (ins_fire && valid_q[i] && age_q[i] != '1)
                    age_q[i] <= age_q[i] + 1'b1;
            end
            if (ins_fire) begin
                valid_q[ins_idx_o] <= 1'b1;
                rdy_q[ins_idx_o]   <= ins_rdy_i | wake_i[ins_idx_o];
                age_q[ins_idx_o]   <= '0;
                tag_q[ins_idx_o]   <= ins_tag_i;
            end
            if (iss_fire)
                valid_q[iss_idx_o] <= 1'b0;
            case (state_q)
                SEL: begin
                    if (iss_valid_o && !iss_ready_i) begin
                        lock_q  <= sel_idx;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (iss_ready_i)
                        state_q <= SEL;
                end
                default: state_q <= SEL;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_queue_sched.sv
// Bench for issue_queue_sched: two instances (AGE_LEN 4 and 2) share directed stimulus
// and are checked every cycle against an insertion-order model of the queue.
module tb_issue_queue_sched;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       ins_valid = 1'b0;
    logic [5:0] ins_tag = '0;
    logic       ins_rdy = 1'b0;
    logic [7:0] wake = '0;
    logic       iss_ready = 1'b0;

    logic       o_ins_ready [2];
    logic [2:0] o_ins_idx   [2];
    logic       o_iss_valid [2];
    logic [2:0] o_iss_idx   [2];
    logic [5:0] o_iss_tag   [2];
    logic [3:0] o_count     [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    issue_queue_sched u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .ins_valid_i(ins_valid), .ins_ready_o(o_ins_ready[0]), .ins_tag_i(ins_tag),
        .ins_rdy_i(ins_rdy), .ins_idx_o(o_ins_idx[0]), .wake_i(wake),
        .iss_valid_o(o_iss_valid[0]), .iss_ready_i(iss_ready), .iss_idx_o(o_iss_idx[0]),
        .iss_tag_o(o_iss_tag[0]), .count_o(o_count[0])
    );

    issue_queue_sched #(.AGE_LEN(2)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .ins_valid_i(ins_valid), .ins_ready_o(o_ins_ready[1]), .ins_tag_i(ins_tag),
        .ins_rdy_i(ins_rdy), .ins_idx_o(o_ins_idx[1]), .wake_i(wake),
        .iss_valid_o(o_iss_valid[1]), .iss_ready_i(iss_ready), .iss_idx_o(o_iss_idx[1]),
        .iss_tag_o(o_iss_tag[1]), .count_o(o_count[1])
    );

    // Age is derived from insertion order: inserts accepted after this entry, saturated.
    bit mv [2][N];
    bit mr [2][N];
    int mseq [2][N];
    int mtag [2][N];
    bit mhold [2];
    int mlock [2];
    int mtotal [2];

    bit e_ir [2];
    int e_ii [2];
    bit e_iv [2];
    int e_idx [2];
    int e_tag [2];
    int e_cnt [2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int mage(int m, int i);
        int a = mtotal[m] - 1 - mseq[m][i];
        int s = (m == 0) ? 15 : 3;
        return (a > s) ? s : a;
    endfunction

    function automatic void calc(int m);
        int cnt = 0;
        int first_free = -1;
        int max_age = -1;
        for (int i = 0; i < N; i++) begin
            if (mv[m][i]) cnt++;
            else if (first_free < 0) first_free = i;
        end
        e_cnt[m] = cnt;
        e_ir[m]  = (cnt < N);
        e_ii[m]  = (first_free < 0) ? 0 : first_free;
        if (mhold[m]) begin
            e_iv[m]  = 1'b1;
            e_idx[m] = mlock[m];
        end else begin
            for (int i = 0; i < N; i++)
                if (mv[m][i] && mr[m][i] && mage(m, i) > max_age) max_age = mage(m, i);
            e_iv[m]  = (max_age >= 0);
            e_idx[m] = 0;
            if (e_iv[m]) begin
                for (int i = N - 1; i >= 0; i--)
                    if (mv[m][i] && mr[m][i] && mage(m, i) == max_age) begin
                        e_idx[m] = i;
                        break;
                    end
            end
        end
        e_tag[m] = e_iv[m] ? mtag[m][e_idx[m]] : 0;
    endfunction

    function automatic void mreset(int m);
        for (int i = 0; i < N; i++) begin
            mv[m][i] = 1'b0;
            mr[m][i] = 1'b0;
            mtag[m][i] = 0;
        end
        mhold[m] = 1'b0;
        mlock[m] = 0;
    endfunction

    function automatic void mupdate(int m);
        bit acc;
        bit fire;
        calc(m);
        if (flush) begin
            for (int i = 0; i < N; i++) mv[m][i] = 1'b0;
            mhold[m] = 1'b0;
        end else begin
            acc  = ins_valid && e_ir[m];
            fire = e_iv[m] && iss_ready;
            for (int i = 0; i < N; i++)
                if (mv[m][i] && wake[i]) mr[m][i] = 1'b1;
            if (acc) begin
                mv[m][e_ii[m]]   = 1'b1;
                mr[m][e_ii[m]]   = ins_rdy | wake[e_ii[m]];
                mtag[m][e_ii[m]] = int'(ins_tag);
                mseq[m][e_ii[m]] = mtotal[m];
                mtotal[m]++;
            end
            if (fire) begin
                mv[m][e_idx[m]] = 1'b0;
                mhold[m] = 1'b0;
            end else if (e_iv[m]) begin
                mhold[m] = 1'b1;
                mlock[m] = e_idx[m];
            end
        end
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) mreset(m);
            else mupdate(m);
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            calc(m);
            chk($sformatf("u%0d.ins_ready", m), int'(o_ins_ready[m]), int'(e_ir[m]));
            chk($sformatf("u%0d.ins_idx", m),   int'(o_ins_idx[m]),   e_ii[m]);
            chk($sformatf("u%0d.iss_valid", m), int'(o_iss_valid[m]), int'(e_iv[m]));
            chk($sformatf("u%0d.iss_idx", m),   int'(o_iss_idx[m]),   e_idx[m]);
            chk($sformatf("u%0d.iss_tag", m),   int'(o_iss_tag[m]),   e_tag[m]);
            chk($sformatf("u%0d.count", m),     int'(o_count[m]),     e_cnt[m]);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic ins(input int tag, input bit rdy);
        ins_valid = 1'b1;
        ins_tag   = 6'(tag);
        ins_rdy   = rdy;
        cyc();
        ins_valid = 1'b0;
        ins_rdy   = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    task automatic fill(input int base, input int n);
        for (int i = 0; i < n; i++) ins(base + i, 1'b0);
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst.ins_ready", int'(o_ins_ready[0]), 1);
        chk("rst.ins_idx",   int'(o_ins_idx[0]),   0);
        chk("rst.iss_valid", int'(o_iss_valid[0]), 0);
        chk("rst.iss_idx",   int'(o_iss_idx[0]),   0);
        chk("rst.iss_tag",   int'(o_iss_tag[0]),   0);
        chk("rst.count",     int'(o_count[0]),     0);
        rst_n = 1'b1;

        // three ready inserts, drained oldest first
        ins(5, 1'b1);
        chk("t1.count1", int'(o_count[0]), 1);
        chk("t1.idx1", int'(o_ins_idx[0]), 1);
        ins(6, 1'b1);
        chk("t1.count2", int'(o_count[0]), 2);
        ins(7, 1'b1);
        chk("t1.count3", int'(o_count[0]), 3);
        chk("t1.idx3", int'(o_ins_idx[0]), 3);
        chk("t1.tag5", int'(o_iss_tag[0]), 5);
        iss_ready = 1'b1;
        cyc();
        chk("t1.tag6", int'(o_iss_tag[0]), 6);
        chk("t1.cnt_a", int'(o_count[0]), 2);
        cyc();
        chk("t1.tag7", int'(o_iss_tag[0]), 7);
        chk("t1.cnt_b", int'(o_count[0]), 1);
        cyc();
        chk("t1.cnt_c", int'(o_count[0]), 0);
        chk("t1.empty", int'(o_iss_valid[0]), 0);
        iss_ready = 1'b0;

        // full queue rejects a ninth insert; single wake selects slot 3
        fill(10, 8);
        chk("t2.full_rdy", int'(o_ins_ready[0]), 0);
        chk("t2.count8", int'(o_count[0]), 8);
        chk("t2.no_iss", int'(o_iss_valid[0]), 0);
        ins(20, 1'b1);
        chk("t2.reject", int'(o_count[0]), 8);
        wake = 8'b0000_1000;
        cyc();
        wake = '0;
        chk("t2.iss_valid", int'(o_iss_valid[0]), 1);
        chk("t2.iss_idx", int'(o_iss_idx[0]), 3);
        chk("t2.iss_tag", int'(o_iss_tag[0]), 13);
        do_flush();

        // locked choice survives waking an older entry
        fill(10, 8);
        wake = 8'b0001_0000;
        cyc();
        wake = '0;
        chk("t3.offer4", int'(o_iss_idx[0]), 4);
        cyc();
        wake = 8'b0000_0010;
        cyc();
        wake = '0;
        chk("t3.hold_a", int'(o_iss_idx[0]), 4);
        chk("t3.hold_tag", int'(o_iss_tag[0]), 14);
        cyc();
        chk("t3.hold_b", int'(o_iss_idx[0]), 4);
        iss_ready = 1'b1;
        cyc();
        chk("t3.next1", int'(o_iss_idx[0]), 1);
        chk("t3.cnt7", int'(o_count[0]), 7);
        cyc();
        chk("t3.cnt6", int'(o_count[0]), 6);
        iss_ready = 1'b0;
        do_flush();

        // full queue: same-cycle issue and insert, insert retried next cycle
        fill(20, 8);
        wake = 8'b0000_0100;
        cyc();
        wake = '0;
        chk("t5.offer2", int'(o_iss_idx[0]), 2);
        iss_ready = 1'b1;
        ins(30, 1'b1);
        chk("t5.cnt7", int'(o_count[0]), 7);
        chk("t5.free2", int'(o_ins_idx[0]), 2);
        chk("t5.ready", int'(o_ins_ready[0]), 1);
        iss_ready = 1'b0;
        ins(31, 1'b0);
        chk("t5.cnt8", int'(o_count[0]), 8);
        chk("t5.full", int'(o_ins_ready[0]), 0);
        do_flush();

        // saturated ages tie in the narrow-age instance only
        fill(40, 6);
        wake = 8'b0000_0011;
        cyc();
        wake = '0;
        chk("t4.sat_tie", int'(o_iss_idx[1]), 1);
        chk("t4.sat_tag", int'(o_iss_tag[1]), 41);
        chk("t4.wide_old", int'(o_iss_idx[0]), 0);
        do_flush();

        // flush while holding dominates insert, wake and issue
        for (int i = 0; i < 5; i++) ins(50 + i, 1'b1);
        chk("t6.cnt5", int'(o_count[0]), 5);
        flush = 1'b1;
        ins_valid = 1'b1;
        ins_tag = 6'd60;
        ins_rdy = 1'b1;
        wake = 8'hFF;
        iss_ready = 1'b1;
        cyc();
        flush = 1'b0;
        ins_valid = 1'b0;
        ins_rdy = 1'b0;
        wake = '0;
        chk("t6.iss_valid", int'(o_iss_valid[0]), 0);
        chk("t6.count", int'(o_count[0]), 0);
        chk("t6.ins_ready", int'(o_ins_ready[0]), 1);
        chk("t6.ins_idx", int'(o_ins_idx[0]), 0);
        cyc();
        chk("t6.stray_ready", int'(o_count[0]), 0);
        iss_ready = 1'b0;
        wake = 8'hFF;
        cyc();
        wake = '0;
        ins(61, 1'b0);
        chk("t6.wake_empty", int'(o_iss_valid[0]), 0);
        chk("t6.cnt1", int'(o_count[0]), 1);
        do_flush();

        // asynchronous reset between edges
        ins(70, 1'b1);
        ins(71, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7.count", int'(o_count[0]), 0);
        chk("t7.iss_valid", int'(o_iss_valid[0]), 0);
        chk("t7.ins_ready", int'(o_ins_ready[0]), 1);
        chk("t7.count_u1", int'(o_count[1]), 0);
        cyc();
        rst_n = 1'b1;
        repeat (2) cyc();
        chk("t7.after", int'(o_count[0]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
